// File: rtl/rr_storage_irq_ctrl_if.sv
// Bundle between the storage interrupt sequencer and its sources, CSR block and shell IRQ.
// The master side drives pulses, enables, ack and clear; the slave side is the sequencer.
interface rr_storage_irq_ctrl_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned CNT_W   = 32
);
  logic [NUM_SRC-1:0] int_pulse;
  logic [NUM_SRC-1:0] int_enable;
  logic               irq_req;
  logic               irq_ack;
  logic [NUM_SRC-1:0] irq_reason;
  logic               irq_busy;
  logic [NUM_SRC-1:0] overflow;
  logic               overflow_clr;
  logic [CNT_W-1:0]   irq_sent_cnt;
  logic [CNT_W-1:0]   retry_cnt;
  logic [CNT_W-1:0]   spurious_ack_cnt;

  modport master (
    output int_pulse, int_enable, irq_ack, overflow_clr,
    input  irq_req, irq_reason, irq_busy, overflow, irq_sent_cnt, retry_cnt, spurious_ack_cnt
  );

  modport slave (
    input  int_pulse, int_enable, irq_ack, overflow_clr,
    output irq_req, irq_reason, irq_busy, overflow, irq_sent_cnt, retry_cnt, spurious_ack_cnt
  );
endinterface

// File: rtl/rr_storage_irq_ctrl.sv
// Storage backend interrupt sequencer: coalesces source pulses into pending reasons and
// issues acknowledged one-cycle IRQ requests with timeout retry and statistics.
module rr_storage_irq_ctrl #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 32
) (
  input logic                  clk,
  input logic                  rst,
  rr_storage_irq_ctrl_if.slave ctrl_io
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMax = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitAck} state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overflow_q, overflow_d;
  logic [NUM_SRC-1:0] reason_q;
  logic [TW-1:0]      timer_q;
  logic               req_q;
  logic               busy_q;
  logic [CNT_W-1:0]   sent_cnt_q, retry_cnt_q, spur_cnt_q;

  logic [NUM_SRC-1:0] ev, take, inflight, ov_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    ev         = ctrl_io.int_pulse & ctrl_io.int_enable;
    take       = (state_q == StIdle) ? pending_q : '0;
    pending_d  = (pending_q & ~take) | ev;
    // A reason already latched into an outstanding request counts as still in flight.
    inflight   = (state_q != StIdle) ? reason_q : '0;
    ov_set     = ev & ((pending_q & ~take) | inflight);
    overflow_d = (ctrl_io.overflow_clr ? '0 : overflow_q) | ov_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      overflow_q  <= '0;
      reason_q    <= '0;
      timer_q     <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      sent_cnt_q  <= '0;
      retry_cnt_q <= '0;
      spur_cnt_q  <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      req_q      <= 1'b0;
      if (ctrl_io.irq_ack && (state_q != StWaitAck)) spur_cnt_q <= sat_inc(spur_cnt_q);
      unique case (state_q)
        StIdle: begin
          if (|pending_q) begin
            reason_q   <= pending_q;
            state_q    <= StReq;
            req_q      <= 1'b1;
            busy_q     <= 1'b1;
            sent_cnt_q <= sat_inc(sent_cnt_q);
          end
        end
        StReq: begin
          timer_q <= '0;
          state_q <= StWaitAck;
        end
        StWaitAck: begin
          timer_q <= timer_q + TW'(1);
          // Ack takes priority over a coinciding timeout.
          if (ctrl_io.irq_ack) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if ((TIMEOUT != 0) && (timer_q == TMax)) begin
            state_q     <= StReq;
            req_q       <= 1'b1;
            retry_cnt_q <= sat_inc(retry_cnt_q);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_io.irq_req          = req_q;
  assign ctrl_io.irq_reason       = reason_q;
  assign ctrl_io.irq_busy         = busy_q;
  assign ctrl_io.overflow         = overflow_q;
  assign ctrl_io.irq_sent_cnt     = sent_cnt_q;
  assign ctrl_io.retry_cnt        = retry_cnt_q;
  assign ctrl_io.spurious_ack_cnt = spur_cnt_q;

endmodule

// File: tb/tb_rr_storage_irq_ctrl.sv
// Directed bench for rr_storage_irq_ctrl with TIMEOUT=8; expectations are hand-computed
// cycle by cycle relative to the cycle in which each stimulus pulse is driven.
module tb_rr_storage_irq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  rr_storage_irq_ctrl_if #(.NUM_SRC(3), .CNT_W(32)) bus_if ();

  rr_storage_irq_ctrl #(
    .NUM_SRC (3),
    .TIMEOUT (8),
    .CNT_W   (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.int_pulse    = '0;
    bus_if.int_enable   = 3'b111;
    bus_if.irq_ack      = 1'b0;
    bus_if.overflow_clr = 1'b0;
    tick(); tick();
    chk("rst_req", bus_if.irq_req, 0);
    chk("rst_busy", bus_if.irq_busy, 0);
    chk("rst_reason", bus_if.irq_reason, 0);
    chk("rst_ovf", bus_if.overflow, 0);
    chk("rst_sent", bus_if.irq_sent_cnt, 0);
    rst = 1'b0;
    tick();

    // Basic request / ack
    bus_if.int_pulse = 3'b010; tick(); bus_if.int_pulse = '0;
    chk("t1_req_c1", bus_if.irq_req, 0);
    chk("t1_busy_c1", bus_if.irq_busy, 0);
    tick();
    chk("t1_req_c2", bus_if.irq_req, 1);
    chk("t1_reason", bus_if.irq_reason, 3'b010);
    chk("t1_busy_c2", bus_if.irq_busy, 1);
    chk("t1_sent", bus_if.irq_sent_cnt, 1);
    tick();
    chk("t1_req_c3", bus_if.irq_req, 0);
    chk("t1_busy_c3", bus_if.irq_busy, 1);
    repeat (3) tick();
    bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
    chk("t1_busy_ack", bus_if.irq_busy, 0);
    chk("t1_req_ack", bus_if.irq_req, 0);
    chk("t1_retry", bus_if.retry_cnt, 0);
    chk("t1_spur", bus_if.spurious_ack_cnt, 0);

    // Coalescing while waiting for ack
    bus_if.int_pulse = 3'b010; tick(); bus_if.int_pulse = '0;
    tick();
    chk("t2_req1", bus_if.irq_req, 1);
    chk("t2_sent1", bus_if.irq_sent_cnt, 2);
    tick();
    bus_if.int_pulse = 3'b100; tick();
    bus_if.int_pulse = 3'b001;
    chk("t2_hold1", bus_if.irq_req, 0);
    tick();
    bus_if.int_pulse = '0;
    chk("t2_hold2", bus_if.irq_req, 0);
    bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
    chk("t2_busy_ack", bus_if.irq_busy, 0);
    tick();
    chk("t2_req2", bus_if.irq_req, 1);
    chk("t2_reason2", bus_if.irq_reason, 3'b101);
    chk("t2_ovf", bus_if.overflow, 0);
    chk("t2_sent2", bus_if.irq_sent_cnt, 3);
    tick();
    bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
    chk("t2_idle", bus_if.irq_busy, 0);

    // Overflow set, clear, and set-beats-clear
    bus_if.int_pulse = 3'b001; tick(); bus_if.int_pulse = '0;
    tick();
    chk("t3_reason", bus_if.irq_reason, 3'b001);
    chk("t3_sent", bus_if.irq_sent_cnt, 4);
    tick();
    bus_if.int_pulse = 3'b001; tick();
    chk("t3_ovf_a", bus_if.overflow, 3'b001);
    tick();
    bus_if.int_pulse = '0;
    chk("t3_ovf_b", bus_if.overflow, 3'b001);
    bus_if.overflow_clr = 1'b1; tick();
    chk("t3_ovf_clr", bus_if.overflow, 0);
    bus_if.int_pulse = 3'b001; tick();
    bus_if.int_pulse = '0; bus_if.overflow_clr = 1'b0;
    chk("t3_ovf_setwins", bus_if.overflow, 3'b001);
    bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
    chk("t3_idle", bus_if.irq_busy, 0);
    tick();
    chk("t3_req2", bus_if.irq_req, 1);
    chk("t3_reason2", bus_if.irq_reason, 3'b001);
    chk("t3_sent2", bus_if.irq_sent_cnt, 5);
    tick();
    bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
    chk("t3_ovf_sticky", bus_if.overflow, 3'b001);
    bus_if.overflow_clr = 1'b1; tick(); bus_if.overflow_clr = 1'b0;
    chk("t3_ovf_clr2", bus_if.overflow, 0);

    // Timeout retry every 9 cycles, ack on the exact timeout cycle
    bus_if.int_pulse = 3'b100; tick(); bus_if.int_pulse = '0;
    tick();
    chk("t4_req0", bus_if.irq_req, 1);
    chk("t4_sent0", bus_if.irq_sent_cnt, 6);
    chk("t4_retry0", bus_if.retry_cnt, 0);
    tick();
    chk("t4_gap_start", bus_if.irq_req, 0);
    repeat (7) tick();
    chk("t4_gap_end", bus_if.irq_req, 0);
    tick();
    chk("t4_req1", bus_if.irq_req, 1);
    chk("t4_retry1", bus_if.retry_cnt, 1);
    chk("t4_sent1", bus_if.irq_sent_cnt, 6);
    chk("t4_reason1", bus_if.irq_reason, 3'b100);
    repeat (8) tick();
    chk("t4_gap2_end", bus_if.irq_req, 0);
    tick();
    chk("t4_req2", bus_if.irq_req, 1);
    chk("t4_retry2", bus_if.retry_cnt, 2);
    chk("t4_reason2", bus_if.irq_reason, 3'b100);
    repeat (8) tick();
    chk("t4_wait_req", bus_if.irq_req, 0);
    chk("t4_wait_busy", bus_if.irq_busy, 1);
    bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
    chk("t4_ackwins_busy", bus_if.irq_busy, 0);
    chk("t4_ackwins_req", bus_if.irq_req, 0);
    tick();
    chk("t4_noretry_req", bus_if.irq_req, 0);
    chk("t4_noretry_cnt", bus_if.retry_cnt, 2);

    // Disabled source and spurious ack
    bus_if.int_enable = 3'b011;
    bus_if.int_pulse = 3'b100; tick(); bus_if.int_pulse = '0;
    chk("t5_busy_a", bus_if.irq_busy, 0);
    tick();
    chk("t5_req", bus_if.irq_req, 0);
    chk("t5_ovf", bus_if.overflow, 0);
    tick();
    bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
    chk("t5_spur", bus_if.spurious_ack_cnt, 1);
    chk("t5_busy_b", bus_if.irq_busy, 0);
    tick();
    chk("t5_busy_c", bus_if.irq_busy, 0);
    bus_if.int_enable = 3'b111;

    // Reset during WAIT_ACK with a pending reason
    bus_if.int_pulse = 3'b010; tick(); bus_if.int_pulse = '0;
    tick();
    chk("t6_req", bus_if.irq_req, 1);
    chk("t6_sent", bus_if.irq_sent_cnt, 7);
    tick();
    bus_if.int_pulse = 3'b100; tick();
    bus_if.int_pulse = 3'b010; tick();
    bus_if.int_pulse = '0;
    chk("t6_ovf_pre", bus_if.overflow, 3'b010);
    chk("t6_busy_pre", bus_if.irq_busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_busy_rst", bus_if.irq_busy, 0);
    chk("t6_reason_rst", bus_if.irq_reason, 0);
    chk("t6_ovf_rst", bus_if.overflow, 0);
    chk("t6_req_rst", bus_if.irq_req, 0);
    chk("t6_sent_rst", bus_if.irq_sent_cnt, 0);
    chk("t6_retry_rst", bus_if.retry_cnt, 0);
    chk("t6_spur_rst", bus_if.spurious_ack_cnt, 0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t6_quiet_req", bus_if.irq_req, 0);
      chk("t6_quiet_busy", bus_if.irq_busy, 0);
    end
    bus_if.int_pulse = 3'b001; tick(); bus_if.int_pulse = '0;
    tick();
    chk("t6_new_req", bus_if.irq_req, 1);
    chk("t6_new_reason", bus_if.irq_reason, 3'b001);
    chk("t6_new_sent", bus_if.irq_sent_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
